// File: rtl/level_expand_pkg.sv
// Shared widths, level-shift offset helper and stage-A payload type for level_expand_pipe.
package level_expand_pkg;

    localparam int unsigned DEF_INW  = 16;
    localparam int unsigned DEF_OUTW = 8;
    localparam int unsigned DEF_CNTW = 16;
    // Widest sample the stage-A payload can carry; narrower samples are zero-extended.
    localparam int unsigned MAX_OUTW = 16;

    // Level shift applied in signed mode: 2^(outw-1).
    function automatic int unsigned LEVEL_OFFSET(input int unsigned outw);
        return 32'd1 << (outw - 32'd1);
    endfunction

    typedef struct packed {
        logic [MAX_OUTW-1:0] value;
        logic                signed_mode;
        logic                last;
    } stage_payload_t;

endpackage

// File: rtl/level_expand_if.sv
// Sample-in / expanded-sample-out stream bundle for level_expand_pipe.
interface level_expand_if
    import level_expand_pkg::*;
#(
    parameter int unsigned INW  = DEF_INW,
    parameter int unsigned OUTW = DEF_OUTW
);

    logic                   i_valid;
    logic                   o_ready;
    logic [OUTW-1:0]        i_value;
    logic                   i_negClamp;
    logic                   i_posClamp;
    logic                   i_last;
    logic                   i_signedMode;
    logic                   o_valid;
    logic                   i_ready;
    logic signed [INW-1:0]  o_value;
    logic                   o_last;

    modport master (
        output i_valid, i_value, i_negClamp, i_posClamp, i_last, i_signedMode, i_ready,
        input  o_ready, o_valid, o_value, o_last
    );

    modport slave (
        input  i_valid, i_value, i_negClamp, i_posClamp, i_last, i_signedMode, i_ready,
        output o_ready, o_valid, o_value, o_last
    );

endinterface

// File: rtl/level_expand_stage.sv
// One valid/ready register slice; loads whenever it is empty or its content is taken.
module level_expand_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         i_nrst,
    input  logic         i_valid,
    output logic         o_ready_c,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load;

    assign w_load    = !r_valid || i_ready;
    assign o_ready_c = w_load;
    assign o_valid   = r_valid;
    assign o_data    = r_data;

    // Data only captured on a real transfer so a stalled slice holds its content.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/level_expand_pipe.sv
// Two-stage expander of clamped unsigned samples to signed working width, with
// per-block clamp-event counters built only when LEVEL_EXPAND_FLAGCNT_EN is defined.
module level_expand_pipe
    import level_expand_pkg::*;
#(
    parameter int unsigned INW  = DEF_INW,
    parameter int unsigned OUTW = DEF_OUTW,
    parameter int unsigned CNTW = DEF_CNTW
) (
    input  logic             clk,
    input  logic             i_nrst,
    level_expand_if.slave    bus,
    input  logic             i_clrCnt,
    output logic [CNTW-1:0]  o_negCnt,
    output logic [CNTW-1:0]  o_posCnt,
    output logic             o_cntValid
);

    localparam int unsigned    AW     = $bits(stage_payload_t);
    localparam int unsigned    BW     = INW + 1;
    localparam logic [INW-1:0] OFFSET = INW'(LEVEL_OFFSET(OUTW));

    stage_payload_t  w_a_in;
    stage_payload_t  w_a_out;
    logic [AW-1:0]   w_a_q;
    logic            w_a_valid;
    logic            w_a_ready_c;
    logic            w_b_ready_c;
    logic [INW-1:0]  w_ext;
    logic [INW-1:0]  w_expanded;
    logic [BW-1:0]   w_b_in;
    logic [BW-1:0]   w_b_q;

    always_comb begin
        w_a_in             = '0;
        w_a_in.value       = MAX_OUTW'(bus.i_value);
        w_a_in.signed_mode = bus.i_signedMode;
        w_a_in.last        = bus.i_last;
    end

    level_expand_stage #(.W(AW)) u_stage_a (
        .clk       (clk),
        .i_nrst    (i_nrst),
        .i_valid   (bus.i_valid),
        .o_ready_c (w_a_ready_c),
        .i_data    (w_a_in),
        .o_valid   (w_a_valid),
        .i_ready   (w_b_ready_c),
        .o_data    (w_a_q)
    );

    assign w_a_out = stage_payload_t'(w_a_q);

    // Expansion sits between the slices; the subtraction wraps into two's complement.
    always_comb begin
        w_ext      = INW'(w_a_out.value);
        w_expanded = w_a_out.signed_mode ? (w_ext - OFFSET) : w_ext;
        w_b_in     = {w_expanded, w_a_out.last};
    end

    level_expand_stage #(.W(BW)) u_stage_b (
        .clk       (clk),
        .i_nrst    (i_nrst),
        .i_valid   (w_a_valid),
        .o_ready_c (w_b_ready_c),
        .i_data    (w_b_in),
        .o_valid   (bus.o_valid),
        .i_ready   (bus.i_ready),
        .o_data    (w_b_q)
    );

    assign bus.o_ready = w_a_ready_c;
    assign bus.o_value = w_b_q[BW-1:1];
    assign bus.o_last  = w_b_q[0];

`ifdef LEVEL_EXPAND_FLAGCNT_EN

    logic            w_accept;
    logic [CNTW-1:0] w_sum_neg;
    logic [CNTW-1:0] w_sum_pos;
    logic [CNTW-1:0] r_run_neg;
    logic [CNTW-1:0] r_run_pos;
    logic [CNTW-1:0] r_neg_cnt;
    logic [CNTW-1:0] r_pos_cnt;
    logic            r_cnt_valid;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] base, input logic inc);
        return (inc && (base != '1)) ? (base + CNTW'(1)) : base;
    endfunction

    assign w_accept = bus.i_valid && w_a_ready_c;

    // Running count including the current sample; a clear drops the history first.
    always_comb begin
        w_sum_neg = sat_inc(i_clrCnt ? '0 : r_run_neg, w_accept && bus.i_negClamp);
        w_sum_pos = sat_inc(i_clrCnt ? '0 : r_run_pos, w_accept && bus.i_posClamp);
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_run_neg   <= '0;
            r_run_pos   <= '0;
            r_neg_cnt   <= '0;
            r_pos_cnt   <= '0;
            r_cnt_valid <= 1'b0;
        end else begin
            r_cnt_valid <= 1'b0;
            if (w_accept && bus.i_last) begin
                r_neg_cnt   <= w_sum_neg;
                r_pos_cnt   <= w_sum_pos;
                r_cnt_valid <= 1'b1;
                r_run_neg   <= '0;
                r_run_pos   <= '0;
            end else begin
                r_run_neg   <= w_sum_neg;
                r_run_pos   <= w_sum_pos;
            end
        end
    end

    assign o_negCnt   = r_neg_cnt;
    assign o_posCnt   = r_pos_cnt;
    assign o_cntValid = r_cnt_valid;

`else

    logic w_unused_cnt_inputs;

    assign w_unused_cnt_inputs = ^{i_clrCnt, bus.i_negClamp, bus.i_posClamp};
    assign o_negCnt   = '0;
    assign o_posCnt   = '0;
    assign o_cntValid = 1'b0;

`endif

endmodule

// File: tb/tb_level_expand_pipe.sv
// Scoreboard bench for level_expand_pipe: directed samples push expectations, a monitor pops and compares.
module tb_level_expand_pipe;

    localparam int unsigned INW   = 16;
    localparam int unsigned OUTW  = 8;
    localparam int unsigned CNTW  = 16;
    localparam int unsigned SCNTW = 4;

    typedef struct {
        logic [INW-1:0] v;
        logic           last;
        int             acc;
        int             lat;
    } exp_t;

    typedef struct {
        logic [CNTW-1:0] neg;
        logic [CNTW-1:0] pos;
    } cnt_t;

    logic             clk = 1'b0;
    logic             i_nrst = 1'b0;
    logic             i_clrCnt = 1'b0;
    logic             s_clr = 1'b0;
    logic [CNTW-1:0]  o_negCnt;
    logic [CNTW-1:0]  o_posCnt;
    logic             o_cntValid;
    logic [SCNTW-1:0] s_negCnt;
    logic [SCNTW-1:0] s_posCnt;
    logic             s_cntValid;

    exp_t exp_q[$];
    cnt_t cnt_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   stall_lo = -100;
    logic force_stall = 1'b0;
    logic saw_full = 1'b0;

    level_expand_if #(.INW(INW), .OUTW(OUTW)) bus ();
    level_expand_if #(.INW(INW), .OUTW(OUTW)) sbus ();

    level_expand_pipe #(.INW(INW), .OUTW(OUTW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .i_nrst     (i_nrst),
        .bus        (bus),
        .i_clrCnt   (i_clrCnt),
        .o_negCnt   (o_negCnt),
        .o_posCnt   (o_posCnt),
        .o_cntValid (o_cntValid)
    );

    level_expand_pipe #(.INW(INW), .OUTW(OUTW), .CNTW(SCNTW)) dut_sat (
        .clk        (clk),
        .i_nrst     (i_nrst),
        .bus        (sbus),
        .i_clrCnt   (s_clr),
        .o_negCnt   (s_negCnt),
        .o_posCnt   (s_posCnt),
        .o_cntValid (s_cntValid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Downstream ready: low during a 4-cycle window or while forced.
    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.i_ready = !(force_stall || (cyc >= stall_lo && cyc < stall_lo + 4));
        end
    end

    // Monitor: pops expectations whenever the DUT completes an output or publishes counts.
    initial begin
        exp_t e;
        cnt_t c;
        forever begin
            @(negedge clk);
            #2;
            if (i_nrst) begin
                if (!bus.i_ready && !bus.o_ready) saw_full = 1'b1;
                if (bus.o_valid && bus.i_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_evt("unexpected_output");
                    end else begin
                        e = exp_q.pop_front();
                        chk("o_value", 32'({bus.o_value}), 32'(e.v));
                        chk("o_last", 32'(bus.o_last), 32'(e.last));
                        if (e.lat != 0) chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                end
`ifdef LEVEL_EXPAND_FLAGCNT_EN
                if (o_cntValid) begin
                    if (cnt_q.size() == 0) begin
                        fail_evt("unexpected_cntValid");
                    end else begin
                        c = cnt_q.pop_front();
                        chk("o_negCnt", 32'(o_negCnt), 32'(c.neg));
                        chk("o_posCnt", 32'(o_posCnt), 32'(c.pos));
                    end
                end
`else
                if (o_cntValid || (o_negCnt != '0) || (o_posCnt != '0)) fail_evt("cnt_not_tied_off");
`endif
            end
        end
    end

    // Present one sample; called and returns at a falling edge.
    task automatic send(input int val, input int sm, input int neg, input int pos, input int last,
                        input int clr, input int ev, input int lat, input int en = 0, input int ep = 0);
        exp_t e;
        cnt_t c;
        bit   done;
        done             = 1'b0;
        bus.i_value      = OUTW'(val);
        bus.i_signedMode = (sm != 0);
        bus.i_negClamp   = (neg != 0);
        bus.i_posClamp   = (pos != 0);
        bus.i_last       = (last != 0);
        i_clrCnt         = (clr != 0);
        bus.i_valid      = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (bus.o_ready) begin
                e.v = INW'(ev);
                e.last = (last != 0);
                e.acc = cyc;
                e.lat = lat;
                exp_q.push_back(e);
`ifdef LEVEL_EXPAND_FLAGCNT_EN
                if (last != 0) begin
                    c.neg = CNTW'(en);
                    c.pos = CNTW'(ep);
                    cnt_q.push_back(c);
                end
`else
                c.neg = CNTW'(en + ep);
                c.pos = c.neg;
`endif
                done = 1'b1;
            end
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        i_clrCnt    = 1'b0;
        if (!done) fail_evt("send_timeout");
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_o_valid"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_o_value"}, 32'({bus.o_value}), 32'd0);
        chk({tag, "_o_last"}, 32'(bus.o_last), 32'd0);
        chk({tag, "_o_ready"}, 32'(bus.o_ready), 32'd1);
        chk({tag, "_o_negCnt"}, 32'(o_negCnt), 32'd0);
        chk({tag, "_o_posCnt"}, 32'(o_posCnt), 32'd0);
        chk({tag, "_o_cntValid"}, 32'(o_cntValid), 32'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (exp_q.size() != 0 || cnt_q.size() != 0); k++) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("cnt_q_empty", 32'(cnt_q.size()), 32'd0);
    endtask

    initial begin
        int sat_exp;
        bus.i_valid = 1'b0;  bus.i_value = '0;   bus.i_negClamp = 1'b0;
        bus.i_posClamp = 1'b0; bus.i_last = 1'b0; bus.i_signedMode = 1'b0;
        sbus.i_valid = 1'b0; sbus.i_value = '0;  sbus.i_negClamp = 1'b0;
        sbus.i_posClamp = 1'b0; sbus.i_last = 1'b0; sbus.i_signedMode = 1'b0;
        sbus.i_ready = 1'b1;

        repeat (3) @(negedge clk);
        i_nrst = 1'b1;
        #2;
        check_reset_state("reset");
        @(negedge clk);

        // Unsigned, full throughput: latency 2 each.
        send(0,   0, 0, 0, 0, 0, 0,   2);
        send(127, 0, 0, 0, 0, 0, 127, 2);
        send(255, 0, 0, 0, 1, 0, 255, 2, 0, 0);
        // Signed: subtract 128.
        send(0,   1, 0, 0, 0, 0, -128, 2);
        send(128, 1, 0, 0, 0, 0, 0,    2);
        send(255, 1, 0, 0, 0, 0, 127,  2);

        // Back-pressure: ready low for 4 cycles while six samples stream.
        stall_lo = cyc + 2;
        send(10,  0, 0, 0, 0, 0, 10,  0);
        send(20,  0, 0, 0, 0, 0, 20,  0);
        send(30,  1, 0, 0, 0, 0, -98, 0);
        send(200, 1, 0, 0, 0, 0, 72,  0);
        send(250, 0, 0, 0, 0, 0, 250, 0);
        send(5,   0, 0, 0, 1, 0, 5,   0, 0, 0);
        drain();
        chk("saw_full", 32'(saw_full), 32'd1);

        // Block of 5: neg on 1 and 3, pos on 4.
        send(1, 0, 1, 0, 0, 0, 1, 0);
        send(2, 0, 0, 0, 0, 0, 2, 0);
        send(3, 0, 1, 0, 0, 0, 3, 0);
        send(4, 0, 0, 1, 0, 0, 4, 0);
        send(5, 0, 0, 0, 1, 0, 5, 0, 2, 1);
        // Next block starts from zero.
        send(6, 0, 0, 0, 0, 0, 6, 0);
        send(7, 0, 0, 1, 1, 0, 7, 0, 0, 1);
        // Clear together with last: only that sample's flags.
        send(8,  0, 1, 0, 0, 0, 8,  0);
        send(9,  0, 1, 0, 0, 0, 9,  0);
        send(10, 0, 0, 1, 1, 1, 10, 0, 0, 1);
        // Clear mid-block keeps the current sample's flag.
        send(11, 0, 1, 0, 0, 0, 11, 0);
        send(12, 0, 1, 0, 0, 1, 12, 0);
        send(13, 0, 0, 0, 1, 0, 13, 0, 1, 0);
        drain();

        // Reset mid-block with two samples held in the pipe.
        force_stall = 1'b1;
        repeat (2) @(negedge clk);
        send(50, 0, 1, 0, 0, 0, 50, 0);
        send(51, 0, 0, 1, 0, 0, 51, 0);
        #2;
        chk("pre_reset_o_valid", 32'(bus.o_valid), 32'd1);
        @(negedge clk);
        i_nrst = 1'b0;
        #2;
        check_reset_state("midreset");
        exp_q.delete();
        cnt_q.delete();
        @(negedge clk);
        i_nrst = 1'b1;
        force_stall = 1'b0;
        @(negedge clk);
        send(60, 0, 1, 0, 1, 0, 60, 0, 1, 0);
        drain();

        // Saturation on the 4-bit counter instance: 20 neg samples then last.
        for (int k = 0; k < 21; k++) begin
            sbus.i_valid    = 1'b1;
            sbus.i_value    = OUTW'(k);
            sbus.i_negClamp = (k < 20);
            sbus.i_last     = (k == 20);
            @(negedge clk);
        end
        sbus.i_valid = 1'b0;
        sbus.i_last  = 1'b0;
        #2;
`ifdef LEVEL_EXPAND_FLAGCNT_EN
        sat_exp = 15;
        chk("sat_cntValid", 32'(s_cntValid), 32'd1);
`else
        sat_exp = 0;
        chk("sat_cntValid", 32'(s_cntValid), 32'd0);
`endif
        chk("sat_negCnt", 32'(s_negCnt), 32'(sat_exp));
        chk("sat_posCnt", 32'(s_posCnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
